// File: rtl/ex_mem_wb_latch.sv
// rtl/ex_mem_wb_latch.sv - EX/MEM and MEM/WB pipeline registers with data-memory handshake
//
// Optional feature macro: MEM_STALL_COUNT_EN (builds the saturating memory-stall counter;
// when undefined stall_cycles is tied to zero).
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   enable, flush_ex_mem global advance from hazard unit, bubble request for EX/MEM
//   ex_*                 EX-stage instruction fields captured into EX/MEM
//   dhit, dmemload       data cache completion and load data
//   dmemREN/WEN/addr/store  data cache request
//   mem_stall            EX/MEM blocked on memory
//   *_EX_MEM, *_mem      EX/MEM fields for forwarding
//   *_MEM_WB, *_wb       MEM/WB fields for register-file write and forwarding
//   halt_wb              sticky halt
//   stall_cycles         memory-stall cycle count
module ex_mem_wb_latch #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enable,
  input  logic              flush_ex_mem,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic              ex_WEN,
  input  logic [REG_W-1:0]  ex_reg_wr,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [OP_W-1:0]   opcode_EX_MEM,
  output logic              WEN_EX_MEM,
  output logic [REG_W-1:0]  reg_wr_mem,
  output logic [WORD_W-1:0] alu_out_mem,
  output logic [OP_W-1:0]   opcode_MEM_WB,
  output logic              WEN_MEM_WB,
  output logic [REG_W-1:0]  reg_wr_wb,
  output logic [WORD_W-1:0] wb_data,
  output logic              halt_wb,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] store_data_mem;
  logic [WORD_W-1:0] load_buf;
  logic              dren_mem;
  logic              dwen_mem;
  logic              halt_mem;
  logic              advance;
  logic [WORD_W-1:0] mem_result;

  // dhit releases the stall combinationally so the load retires on its hit cycle.
  assign mem_stall = (state == ACCESS) && !dhit;
  assign advance   = enable && !mem_stall;

  assign dmemREN   = (state == ACCESS) && dren_mem;
  assign dmemWEN   = (state == ACCESS) && dwen_mem;
  assign dmemaddr  = alu_out_mem;
  assign dmemstore = store_data_mem;

  // Result heading to WB: live cache data on the hit cycle, the buffered copy
  // when the hit arrived while the pipeline was frozen, otherwise the ALU value.
  always_comb begin
    mem_result = alu_out_mem;
    if (dren_mem && (state == ACCESS)) begin
      mem_result = dmemload;
    end else if (dren_mem && (state == DONE)) begin
      mem_result = load_buf;
    end
  end

  // EX/MEM register and memory-handshake FSM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      opcode_EX_MEM  <= '0;
      WEN_EX_MEM     <= 1'b0;
      reg_wr_mem     <= '0;
      alu_out_mem    <= '0;
      store_data_mem <= '0;
      dren_mem       <= 1'b0;
      dwen_mem       <= 1'b0;
      halt_mem       <= 1'b0;
      load_buf       <= '0;
    end else if (advance) begin
      if (flush_ex_mem) begin
        state          <= IDLE;
        opcode_EX_MEM  <= '0;
        WEN_EX_MEM     <= 1'b0;
        reg_wr_mem     <= '0;
        alu_out_mem    <= '0;
        store_data_mem <= '0;
        dren_mem       <= 1'b0;
        dwen_mem       <= 1'b0;
        halt_mem       <= 1'b0;
      end else begin
        state          <= (ex_dREN || ex_dWEN) ? ACCESS : IDLE;
        opcode_EX_MEM  <= ex_opcode;
        WEN_EX_MEM     <= ex_WEN;
        reg_wr_mem     <= ex_reg_wr;
        alu_out_mem    <= ex_alu_out;
        store_data_mem <= ex_store_data;
        dren_mem       <= ex_dREN;
        // Load and store together is illegal; the load wins.
        dwen_mem       <= ex_dWEN && !ex_dREN;
        halt_mem       <= ex_halt;
      end
    end else if ((state == ACCESS) && dhit && !enable) begin
      // Hit while frozen: drop the request so a store is not repeated.
      load_buf <= dmemload;
      state    <= DONE;
    end
  end

  // MEM/WB register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      opcode_MEM_WB <= '0;
      WEN_MEM_WB    <= 1'b0;
      reg_wr_wb     <= '0;
      wb_data       <= '0;
      halt_wb       <= 1'b0;
    end else if (advance) begin
      opcode_MEM_WB <= opcode_EX_MEM;
      WEN_MEM_WB    <= WEN_EX_MEM;
      reg_wr_wb     <= reg_wr_mem;
      wb_data       <= mem_result;
      if (halt_mem) begin
        halt_wb <= 1'b1;
      end
    end else if (enable) begin
      // Stalled on memory: insert a bubble so the older write is not repeated.
      opcode_MEM_WB <= '0;
      WEN_MEM_WB    <= 1'b0;
      reg_wr_wb     <= '0;
    end
  end

`ifdef MEM_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (mem_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_wb_latch.sv
// tb/tb_ex_mem_wb_latch.sv - self-checking bench for ex_mem_wb_latch
module tb_ex_mem_wb_latch;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;

  logic              CLK;
  logic              nRST;
  logic              enable;
  logic              flush_ex_mem;
  logic [OP_W-1:0]   ex_opcode;
  logic              ex_WEN;
  logic [REG_W-1:0]  ex_reg_wr;
  logic [WORD_W-1:0] ex_alu_out;
  logic [WORD_W-1:0] ex_store_data;
  logic              ex_dREN;
  logic              ex_dWEN;
  logic              ex_halt;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;
  logic [OP_W-1:0]   opcode_EX_MEM;
  logic              WEN_EX_MEM;
  logic [REG_W-1:0]  reg_wr_mem;
  logic [WORD_W-1:0] alu_out_mem;
  logic [OP_W-1:0]   opcode_MEM_WB;
  logic              WEN_MEM_WB;
  logic [REG_W-1:0]  reg_wr_wb;
  logic [WORD_W-1:0] wb_data;
  logic              halt_wb;
  logic [31:0]       stall_cycles;

  int checks   = 0;
  int failures = 0;

  ex_mem_wb_latch #(.WORD_W(WORD_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .CLK(CLK), .nRST(nRST), .enable(enable), .flush_ex_mem(flush_ex_mem),
    .ex_opcode(ex_opcode), .ex_WEN(ex_WEN), .ex_reg_wr(ex_reg_wr),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .opcode_EX_MEM(opcode_EX_MEM), .WEN_EX_MEM(WEN_EX_MEM),
    .reg_wr_mem(reg_wr_mem), .alu_out_mem(alu_out_mem), .opcode_MEM_WB(opcode_MEM_WB),
    .WEN_MEM_WB(WEN_MEM_WB), .reg_wr_wb(reg_wr_wb), .wb_data(wb_data),
    .halt_wb(halt_wb), .stall_cycles(stall_cycles)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction as seen by the reference model.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              wen;
    logic [REG_W-1:0]  rd;
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] sd;
    logic              ld;
    logic              st;
    logic              halt;
  } instr_t;

  instr_t            m_em;
  logic              m_pend;
  logic [WORD_W-1:0] m_buf;
  logic [OP_W-1:0]   m_wb_op;
  logic              m_wb_wen;
  logic [REG_W-1:0]  m_wb_rd;
  logic [WORD_W-1:0] m_wb_data;
  logic              m_halt;
  logic [31:0]       m_cnt;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    enable = 1'b1; flush_ex_mem = 1'b0; ex_opcode = '0; ex_WEN = 1'b0; ex_reg_wr = '0;
    ex_alu_out = '0; ex_store_data = '0; ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_halt = 1'b0;
    dhit = 1'b0; dmemload = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    ex_opcode = 6'h23; ex_dREN = 1'b1; ex_alu_out = 32'h55; enable = 1'b1;
    nRST = 1'b0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, halt_wb} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {dmemREN, dmemWEN, mem_stall, halt_wb});
    end
    checks++;
    if ({WEN_EX_MEM, reg_wr_mem, alu_out_mem, WEN_MEM_WB, reg_wr_wb, wb_data} !== '0) begin
      failures++; $display("FAIL reset_regs wen_mem=%b rd_mem=%0d wb_data=%h exp 0", WEN_EX_MEM, reg_wr_mem, wb_data);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", stall_cycles);
    end
    do_reset();
  endtask

  task automatic test_alu();
    logic [WORD_W-1:0] v;
    do_reset();
    v = $urandom;
    ex_opcode = 6'h00; ex_WEN = 1'b1; ex_reg_wr = 5'd5; ex_alu_out = v;
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({reg_wr_mem, WEN_EX_MEM, alu_out_mem} !== {5'd5, 1'b1, v}) begin
      failures++; $display("FAIL alu_exmem rd=%0d wen=%b alu=%h exp rd=5 wen=1 alu=%h", reg_wr_mem, WEN_EX_MEM, alu_out_mem, v);
    end
    checks++;
    if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      failures++; $display("FAIL alu_noreq got=%b exp=000", {dmemREN, dmemWEN, mem_stall});
    end
    tick();
    checks++;
    if ({reg_wr_wb, WEN_MEM_WB, wb_data} !== {5'd5, 1'b1, v}) begin
      failures++; $display("FAIL alu_memwb rd=%0d wen=%b data=%h exp rd=5 wen=1 data=%h", reg_wr_wb, WEN_MEM_WB, wb_data, v);
    end
  endtask

  task automatic test_load();
    do_reset();
    ex_opcode = 6'h23; ex_WEN = 1'b1; ex_reg_wr = 5'd9; ex_alu_out = 32'h100; ex_dREN = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({dmemREN, mem_stall, dmemaddr} !== {1'b1, 1'b1, 32'h100}) begin
        failures++; $display("FAIL load_wait%0d ren=%b stall=%b addr=%h exp 1 1 100", i, dmemREN, mem_stall, dmemaddr);
      end
      tick();
      checks++;
      if (WEN_MEM_WB !== 1'b0) begin
        failures++; $display("FAIL load_bubble%0d WEN_MEM_WB got=%b exp=0", i, WEN_MEM_WB);
      end
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      failures++; $display("FAIL load_hit_stall got=%b exp=0", mem_stall);
    end
    tick();
    dhit = 1'b0; dmemload = '0;
    #1;
    checks++;
    if ({wb_data, WEN_MEM_WB, reg_wr_wb, dmemREN} !== {32'hDEADBEEF, 1'b1, 5'd9, 1'b0}) begin
      failures++; $display("FAIL load_wb data=%h wen=%b rd=%0d ren=%b exp deadbeef 1 9 0", wb_data, WEN_MEM_WB, reg_wr_wb, dmemREN);
    end
    checks++;
`ifdef MEM_STALL_COUNT_EN
    if (stall_cycles !== 32'd3) begin
      failures++; $display("FAIL load_count got=%0d exp=3", stall_cycles);
    end
`else
    if (stall_cycles !== 32'd0) begin
      failures++; $display("FAIL load_count got=%0d exp=0", stall_cycles);
    end
`endif
  endtask

  task automatic test_store_done();
    do_reset();
    ex_opcode = 6'h2B; ex_alu_out = 32'h40; ex_store_data = 32'h1234; ex_dWEN = 1'b1;
    tick();
    clear_inputs();
    enable = 1'b0;
    #1;
    checks++;
    if ({dmemWEN, dmemREN, dmemaddr, dmemstore} !== {1'b1, 1'b0, 32'h40, 32'h1234}) begin
      failures++; $display("FAIL store_req wen=%b ren=%b addr=%h data=%h exp 1 0 40 1234", dmemWEN, dmemREN, dmemaddr, dmemstore);
    end
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({dmemWEN, mem_stall, alu_out_mem} !== {1'b0, 1'b0, 32'h40}) begin
        failures++; $display("FAIL store_done%0d wen=%b stall=%b addr=%h exp 0 0 40", i, dmemWEN, mem_stall, alu_out_mem);
      end
      tick();
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dmemWEN, dmemREN} !== 2'b00) begin
        failures++; $display("FAIL store_norewrite%0d got=%b exp=00", i, {dmemWEN, dmemREN});
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    ex_opcode = 6'h23; ex_WEN = 1'b1; ex_reg_wr = 5'd7; ex_alu_out = $urandom | 32'h1;
    ex_dREN = 1'b1; ex_halt = 1'b1; flush_ex_mem = 1'b1;
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({WEN_EX_MEM, reg_wr_mem, opcode_EX_MEM, alu_out_mem} !== '0) begin
      failures++; $display("FAIL flush_exmem wen=%b rd=%0d op=%h alu=%h exp 0", WEN_EX_MEM, reg_wr_mem, opcode_EX_MEM, alu_out_mem);
    end
    checks++;
    if ({dmemREN, mem_stall} !== 2'b00) begin
      failures++; $display("FAIL flush_noreq got=%b exp=00", {dmemREN, mem_stall});
    end
    tick();
    tick();
    checks++;
    if (halt_wb !== 1'b0) begin
      failures++; $display("FAIL flush_halt got=%b exp=0", halt_wb);
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    ex_opcode = 6'h00; ex_WEN = 1'b1; ex_reg_wr = 5'd3; ex_alu_out = 32'hA5A5_0001;
    tick();
    ex_opcode = 6'h23; ex_reg_wr = 5'd4; ex_alu_out = 32'h200; ex_dREN = 1'b1;
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({dmemREN, wb_data} !== {1'b1, 32'hA5A5_0001}) begin
      failures++; $display("FAIL rstmid_pre ren=%b wb=%h exp 1 a5a50001", dmemREN, wb_data);
    end
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if ({dmemREN, mem_stall, reg_wr_mem, wb_data, WEN_MEM_WB, reg_wr_wb} !== '0) begin
      failures++; $display("FAIL rstmid_clear ren=%b stall=%b rd=%0d wb=%h exp 0", dmemREN, mem_stall, reg_wr_mem, wb_data);
    end
    tick();
    nRST = 1'b1;
    tick();
    checks++;
    if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      failures++; $display("FAIL rstmid_idle got=%b exp=000", {dmemREN, dmemWEN, mem_stall});
    end
  endtask

  task automatic test_halt();
    do_reset();
    ex_opcode = 6'h3F; ex_halt = 1'b1;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (halt_wb !== 1'b0) begin
      failures++; $display("FAIL halt_early got=%b exp=0", halt_wb);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({halt_wb, opcode_MEM_WB} !== {1'b1, (i == 0) ? 6'h3F : 6'h00}) begin
        failures++; $display("FAIL halt_sticky%0d halt=%b op=%h", i, halt_wb, opcode_MEM_WB);
      end
      tick();
    end
  endtask

  task automatic reset_model();
    m_em = '0; m_pend = 1'b0; m_buf = '0; m_wb_op = '0; m_wb_wen = 1'b0;
    m_wb_rd = '0; m_wb_data = '0; m_halt = 1'b0; m_cnt = '0;
  endtask

  task automatic test_random();
    instr_t n;
    logic   stall;
    logic   adv;
    int     lat;
    do_reset();
    reset_model();
    lat = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 400; cyc++) begin
      enable = ($urandom_range(0, 3) != 0);
      flush_ex_mem = ($urandom_range(0, 9) == 0);
      ex_opcode = OP_W'($urandom); ex_WEN = 1'($urandom); ex_reg_wr = REG_W'($urandom);
      ex_alu_out = $urandom; ex_store_data = $urandom;
      ex_dREN = ($urandom_range(0, 3) == 0); ex_dWEN = ($urandom_range(0, 3) == 0);
      ex_halt = ($urandom_range(0, 99) == 0);
      dmemload = $urandom;
      // Memory responder: hit after a random wait once a request is outstanding.
      if (m_pend) begin
        if (lat == 0) begin
          dhit = 1'b1; lat = $urandom_range(0, 3);
        end else begin
          dhit = 1'b0; lat--;
        end
      end else begin
        dhit = ($urandom_range(0, 4) == 0);
      end
      #1;
      stall = m_pend && !dhit;
      adv   = enable && !stall;
      checks++;
      if ({mem_stall, dmemREN, dmemWEN, dmemaddr, dmemstore} !==
          {stall, m_pend && m_em.ld, m_pend && m_em.st, m_em.alu, m_em.sd}) begin
        failures++;
        $display("FAIL rand_req c%0d stall=%b ren=%b wen=%b addr=%h exp stall=%b ren=%b wen=%b addr=%h",
                 cyc, mem_stall, dmemREN, dmemWEN, dmemaddr, stall, m_pend && m_em.ld, m_pend && m_em.st, m_em.alu);
      end
      n = '{op: ex_opcode, wen: ex_WEN, rd: ex_reg_wr, alu: ex_alu_out, sd: ex_store_data,
            ld: ex_dREN, st: ex_dWEN && !ex_dREN, halt: ex_halt};
      if (stall && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
      if (adv) begin
        m_wb_op = m_em.op; m_wb_wen = m_em.wen; m_wb_rd = m_em.rd;
        m_wb_data = m_em.ld ? (m_pend ? dmemload : m_buf) : m_em.alu;
        if (m_em.halt) m_halt = 1'b1;
        m_em = flush_ex_mem ? '0 : n;
        m_pend = m_em.ld || m_em.st;
      end else begin
        if (enable) begin
          m_wb_op = '0; m_wb_wen = 1'b0; m_wb_rd = '0;
        end
        if (m_pend && dhit) begin
          m_pend = 1'b0; m_buf = dmemload;
        end
      end
      tick();
      checks++;
      if ({opcode_EX_MEM, WEN_EX_MEM, reg_wr_mem, alu_out_mem} !== {m_em.op, m_em.wen, m_em.rd, m_em.alu}) begin
        failures++;
        $display("FAIL rand_exmem c%0d op=%h wen=%b rd=%0d alu=%h exp op=%h wen=%b rd=%0d alu=%h",
                 cyc, opcode_EX_MEM, WEN_EX_MEM, reg_wr_mem, alu_out_mem, m_em.op, m_em.wen, m_em.rd, m_em.alu);
      end
      checks++;
      if ({opcode_MEM_WB, WEN_MEM_WB, reg_wr_wb, wb_data, halt_wb} !== {m_wb_op, m_wb_wen, m_wb_rd, m_wb_data, m_halt}) begin
        failures++;
        $display("FAIL rand_memwb c%0d op=%h wen=%b rd=%0d data=%h halt=%b exp op=%h wen=%b rd=%0d data=%h halt=%b",
                 cyc, opcode_MEM_WB, WEN_MEM_WB, reg_wr_wb, wb_data, halt_wb, m_wb_op, m_wb_wen, m_wb_rd, m_wb_data, m_halt);
      end
      checks++;
`ifdef MEM_STALL_COUNT_EN
      if (stall_cycles !== m_cnt) begin
        failures++; $display("FAIL rand_count c%0d got=%0d exp=%0d", cyc, stall_cycles, m_cnt);
      end
`else
      if (stall_cycles !== 32'd0) begin
        failures++; $display("FAIL rand_count c%0d got=%0d exp=0", cyc, stall_cycles);
      end
`endif
    end
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b1;
    #2;
    test_reset();
    test_alu();
    test_load();
    test_store_done();
    test_flush();
    test_reset_mid_access();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
